// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, widths, response codes and FSM state encodings.
package axi_lite_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  // Slave storage depth; the byte address is used directly as the word index.
  localparam int BUF_DEPTH  = 32;
  localparam int IDX_WIDTH  = 5;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [1:0]            resp_t;

  localparam resp_t RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  // Merge new write data into an existing word, byte lane by byte lane.
  function automatic data_t apply_strb(input data_t old_word, input data_t new_word,
                                       input strb_t strb);
    data_t merged;
    merged = old_word;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with clock and reset, plus master/slave views.
interface axi_lite_if
  import axi_lite_pkg::*;
(
  input logic aclk,
  input logic areset_n
);

  logic  awvalid;
  logic  awready;
  addr_t awaddr;

  logic  wvalid;
  logic  wready;
  data_t wdata;
  strb_t wstrb;

  logic  bvalid;
  logic  bready;
  resp_t bresp;

  logic  arvalid;
  logic  arready;
  addr_t araddr;

  logic  rvalid;
  logic  rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    input  aclk, areset_n,
    output awvalid, awaddr, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    input  aclk, areset_n,
    input  awvalid, awaddr, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/axi_lite_slave.sv
// AXI4-Lite slave backed by a 32-word register file indexed by addr[4:0].
module axi_lite_slave
  import axi_lite_pkg::*;
(
  axi_lite_if.slave s_axi_lite
);

  data_t                buffer [BUF_DEPTH];

  logic                 aw_got_q;
  logic                 w_got_q;
  logic [IDX_WIDTH-1:0] aw_idx_q;
  data_t                wdata_q;
  strb_t                wstrb_q;
  logic                 bvalid_q;

  logic                 ar_pend_q;
  logic                 rvalid_q;
  data_t                rdata_q;

  logic                 aw_fire;
  logic                 w_fire;
  logic                 ar_fire;
  logic                 commit;

  // Each write beat is accepted only until captured; nothing new until B completes.
  assign s_axi_lite.awready = !aw_got_q && !bvalid_q;
  assign s_axi_lite.wready  = !w_got_q && !bvalid_q;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = RESP_OKAY;

  assign s_axi_lite.arready = !ar_pend_q && !rvalid_q;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rdata   = rdata_q;
  assign s_axi_lite.rresp   = RESP_OKAY;

  assign aw_fire = s_axi_lite.awvalid && s_axi_lite.awready;
  assign w_fire  = s_axi_lite.wvalid && s_axi_lite.wready;
  assign ar_fire = s_axi_lite.arvalid && s_axi_lite.arready;
  assign commit  = aw_got_q && w_got_q;

  // Storage: cleared on reset, written the cycle after both write beats are held.
  always_ff @(posedge s_axi_lite.aclk or negedge s_axi_lite.areset_n) begin
    if (!s_axi_lite.areset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= '0;
    end else if (commit) begin
      buffer[aw_idx_q] <= apply_strb(buffer[aw_idx_q], wdata_q, wstrb_q);
    end
  end

  // Write channel capture and B response sequencing.
  always_ff @(posedge s_axi_lite.aclk or negedge s_axi_lite.areset_n) begin
    if (!s_axi_lite.areset_n) begin
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_got_q <= 1'b1;
        aw_idx_q <= s_axi_lite.awaddr[IDX_WIDTH-1:0];
      end
      if (w_fire) begin
        w_got_q <= 1'b1;
        wdata_q <= s_axi_lite.wdata;
        wstrb_q <= s_axi_lite.wstrb;
      end
      if (commit) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bvalid_q <= 1'b1;
      end else if (bvalid_q && s_axi_lite.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: data sampled at AR acceptance (so a same-edge write is not
  // visible), presented on R one cycle later and held until taken.
  always_ff @(posedge s_axi_lite.aclk or negedge s_axi_lite.areset_n) begin
    if (!s_axi_lite.areset_n) begin
      ar_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (ar_fire) begin
        ar_pend_q <= 1'b1;
        rdata_q   <= buffer[s_axi_lite.araddr[IDX_WIDTH-1:0]];
      end
      if (ar_pend_q) begin
        ar_pend_q <= 1'b0;
        rvalid_q  <= 1'b1;
      end else if (rvalid_q && s_axi_lite.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master issuing one fixed write and one fixed read on start pulses.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter addr_t WR_ADDR = 32'h4,
  parameter data_t WR_DATA = 32'hdeadbeef,
  parameter addr_t RD_ADDR = 32'h4
) (
  axi_lite_if.master m_axi_lite,
  input  logic       start_write,
  input  logic       start_read,
  output data_t      rdata
);

  wr_state_e wr_state_q, wr_state_d;
  logic      aw_done_q, aw_done_d;
  logic      w_done_q, w_done_d;
  logic      aw_fire;
  logic      w_fire;

  rd_state_e rd_state_q, rd_state_d;
  data_t     rdata_q, rdata_d;

  assign rdata = rdata_q;

  // State registers for both independent channels.
  always_ff @(posedge m_axi_lite.aclk or negedge m_axi_lite.areset_n) begin
    if (!m_axi_lite.areset_n) begin
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
    end
  end

  // Write FSM: AW and W offered together, each dropped after its own handshake.
  always_comb begin
    wr_state_d            = wr_state_q;
    aw_done_d             = aw_done_q;
    w_done_d              = w_done_q;
    aw_fire               = 1'b0;
    w_fire                = 1'b0;
    m_axi_lite.awvalid    = 1'b0;
    m_axi_lite.awaddr     = '0;
    m_axi_lite.wvalid     = 1'b0;
    m_axi_lite.wdata      = '0;
    m_axi_lite.wstrb      = '0;
    m_axi_lite.bready     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (start_write) begin
          wr_state_d = W_ADDR;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_ADDR: begin
        m_axi_lite.awvalid = !aw_done_q;
        m_axi_lite.awaddr  = WR_ADDR;
        m_axi_lite.wvalid  = !w_done_q;
        m_axi_lite.wdata   = WR_DATA;
        m_axi_lite.wstrb   = '1;
        aw_fire            = !aw_done_q && m_axi_lite.awready;
        w_fire             = !w_done_q && m_axi_lite.wready;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m_axi_lite.bready = 1'b1;
        if (m_axi_lite.bvalid) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read FSM: issue AR, then capture the returned word on the R handshake.
  always_comb begin
    rd_state_d         = rd_state_q;
    rdata_d            = rdata_q;
    m_axi_lite.arvalid = 1'b0;
    m_axi_lite.araddr  = '0;
    m_axi_lite.rready  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (start_read) rd_state_d = R_ADDR;
      end
      R_ADDR: begin
        m_axi_lite.arvalid = 1'b1;
        m_axi_lite.araddr  = RD_ADDR;
        if (m_axi_lite.arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_axi_lite.rready = 1'b1;
        if (m_axi_lite.rvalid) begin
          rdata_d    = m_axi_lite.rdata;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for the AXI4-Lite master talking to the AXI4-Lite slave over one bus.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam logic [31:0] P_WR_ADDR = 32'h4;
  localparam logic [31:0] P_WR_DATA = 32'hdeadbeef;
  localparam logic [31:0] P_RD_ADDR = 32'h4;
  localparam int          WIDX      = 4;
  localparam int          RIDX      = 4;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start_write = 1'b0;
  logic  start_read = 1'b0;
  data_t m_rdata;

  int n_chk = 0;
  int n_fail = 0;

  axi_lite_if bus (.aclk(clk), .areset_n(rst_n));

  axi_lite_master #(
    .WR_ADDR(P_WR_ADDR),
    .WR_DATA(P_WR_DATA),
    .RD_ADDR(P_RD_ADDR)
  ) u_m (
    .m_axi_lite (bus.master),
    .start_write(start_write),
    .start_read (start_read),
    .rdata      (m_rdata)
  );

  axi_lite_slave u_slave (.s_axi_lite(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a write lands in memory two edges after its start
  // pulse is sampled and completes on the third; a read snapshots memory one
  // edge after its start (before any write on that same edge) and updates the
  // master's register on the third edge. Starts while busy are dropped.
  int          e = 0;
  int          ws = 0;
  int          rs = 0;
  bit          wbusy = 1'b0;
  bit          rbusy = 1'b0;
  logic [31:0] mmem [32];
  logic [31:0] snap = '0;
  logic [31:0] exp_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e         <= 0;
      wbusy     <= 1'b0;
      rbusy     <= 1'b0;
      snap      <= '0;
      exp_rdata <= '0;
      for (int i = 0; i < 32; i++) mmem[i] <= '0;
    end else begin
      e <= e + 1;
      if (wbusy && e == ws + 2) mmem[WIDX] <= P_WR_DATA;
      if (wbusy && e == ws + 3) wbusy <= 1'b0;
      if (rbusy && e == rs + 1) snap <= mmem[RIDX];
      if (rbusy && e == rs + 3) begin
        exp_rdata <= snap;
        rbusy     <= 1'b0;
      end
      if (start_write && !wbusy) begin
        wbusy <= 1'b1;
        ws    <= e;
      end
      if (start_read && !rbusy) begin
        rbusy <= 1'b1;
        rs    <= e;
      end
    end
  end

  // Cycle-by-cycle comparison of the bus and observable state against the model.
  always @(negedge clk) begin
    check("awvalid", {31'b0, bus.awvalid}, {31'b0, wbusy && (e == ws + 1)});
    check("wvalid",  {31'b0, bus.wvalid},  {31'b0, wbusy && (e == ws + 1)});
    check("bvalid",  {31'b0, bus.bvalid},  {31'b0, wbusy && (e == ws + 3)});
    check("bready",  {31'b0, bus.bready},  {31'b0, wbusy && (e == ws + 2 || e == ws + 3)});
    check("arvalid", {31'b0, bus.arvalid}, {31'b0, rbusy && (e == rs + 1)});
    check("rvalid",  {31'b0, bus.rvalid},  {31'b0, rbusy && (e == rs + 3)});
    check("rready",  {31'b0, bus.rready},  {31'b0, rbusy && (e == rs + 2 || e == rs + 3)});
    check("rdata",   m_rdata, exp_rdata);
    check("buffer4", u_slave.buffer[4], mmem[4]);
    if (bus.awvalid) check("awaddr", bus.awaddr, P_WR_ADDR);
    if (bus.wvalid) begin
      check("wdata", bus.wdata, P_WR_DATA);
      check("wstrb", {28'b0, bus.wstrb}, 32'hf);
    end
    if (bus.arvalid) check("araddr", bus.araddr, P_RD_ADDR);
    if (bus.bvalid) check("bresp", {30'b0, bus.bresp}, 32'h0);
    if (bus.rvalid) check("rresp", {30'b0, bus.rresp}, 32'h0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse(input bit w, input bit r);
    step(1);
    start_write = w;
    start_read  = r;
    step(1);
    start_write = 1'b0;
    start_read  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    step(1);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;

    // Reset held for ten cycles: everything quiet and zero.
    step(10);
    check("rst_awvalid", {31'b0, bus.awvalid}, 32'h0);
    check("rst_arvalid", {31'b0, bus.arvalid}, 32'h0);
    check("rst_bvalid",  {31'b0, bus.bvalid},  32'h0);
    check("rst_rvalid",  {31'b0, bus.rvalid},  32'h0);
    check("rst_rdata",   m_rdata, 32'h0);
    check("rst_buffer4", u_slave.buffer[4], 32'h0);
    rst_n = 1'b1;

    // Read before any write returns zero.
    pulse(1'b0, 1'b1);
    step(6);
    check("read_fresh", m_rdata, 32'h0);

    // Write, with a second start while busy that must be dropped.
    step(1);
    start_write = 1'b1;
    step(2);
    start_write = 1'b0;
    for (k = 0; k < 10 && u_slave.buffer[4] !== 32'hdeadbeef; k++) step(1);
    check("write_lands", u_slave.buffer[4], 32'hdeadbeef);
    step(6);

    // Read back the written word.
    pulse(1'b0, 1'b1);
    for (k = 0; k < 10 && m_rdata !== 32'hdeadbeef; k++) step(1);
    check("read_back", m_rdata, 32'hdeadbeef);
    step(4);

    // Fresh reset, then simultaneous starts: read sees the pre-write value.
    do_reset(3);
    pulse(1'b1, 1'b1);
    step(8);
    check("simul_rdata", m_rdata, 32'h0);
    check("simul_buf4",  u_slave.buffer[4], 32'hdeadbeef);

    // Reset pulsed while the write address phase is outstanding.
    do_reset(3);
    pulse(1'b1, 1'b0);
    check("mid_awvalid", {31'b0, bus.awvalid}, 32'h1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(6);
    check("abort_buf4",  u_slave.buffer[4], 32'h0);
    check("abort_wr_idle", {30'b0, u_m.wr_state_q}, {30'b0, W_IDLE});
    check("abort_rd_idle", {30'b0, u_m.rd_state_q}, {30'b0, R_IDLE});

    // Operation resumes from idle after the aborted transaction.
    pulse(1'b1, 1'b0);
    for (k = 0; k < 10 && u_slave.buffer[4] !== 32'hdeadbeef; k++) step(1);
    check("resume_write", u_slave.buffer[4], 32'hdeadbeef);
    step(4);
    pulse(1'b0, 1'b1);
    for (k = 0; k < 10 && m_rdata !== 32'hdeadbeef; k++) step(1);
    check("resume_read", m_rdata, 32'hdeadbeef);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
